// File: rtl/mux_sel_scan_if.sv
// Output stream of mux_sel_scan: the selected word, its channel index,
// an error flag, and the valid/ready handshake.
//   master: drives out_data/out_ch/out_err/out_valid, samples out_ready
//   slave : samples the word, drives out_ready
interface mux_sel_scan_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
);
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data, out_ch, out_err, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_ch, out_err, out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux_sel_scan.sv
// N-channel, W-bit registered multiplexer with a valid/ready output.
// Direct mode picks the channel from sel on a sel_valid request; scan mode
// steps a round-robin pointer once every SCAN_DIV clocks (digit scanning).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mode            0 = direct, 1 = scan (registered internally)
//   sel, sel_valid  direct-mode channel select and capture request
//   data_in         flattened channels, channel k = data_in[k*WIDTH +: WIDTH]
//   out_if          output word/channel/error with valid/ready handshake
module mux_sel_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  mux_sel_scan_if.master            out_if
);

  localparam int unsigned       PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]  LAST_CH   = SEL_W'(CHANNELS - 1);

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic             switch_c;
  logic             slot_free;
  logic             tick;
  logic             cap;
  logic [SEL_W-1:0] cap_ch;
  logic [WIDTH-1:0] cap_word;
  logic             cap_err;

  always_comb begin
    mode_d    = mode_e'(mode);
    switch_c  = (mode_d != mode_q);
    slot_free = !valid_q || out_if.out_ready;
    tick      = (mode_q == MODE_SCAN) && (presc_q == PRESC_MAX);

    presc_d = presc_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    cap     = 1'b0;
    cap_ch  = ptr_q;

    if (switch_c) begin
      // Mode change restarts the cadence; no capture in this cycle.
      presc_d = '0;
      pend_d  = 1'b0;
      if (mode_d == MODE_SCAN) begin
        ptr_d = '0;
      end
    end else if (mode_q == MODE_SCAN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      // A single pending flag absorbs any number of ticks under back-pressure,
      // so the pointer never skips a channel.
      if ((pend_q || tick) && slot_free) begin
        cap    = 1'b1;
        cap_ch = ptr_q;
        pend_d = 1'b0;
        ptr_d  = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
      end else if (tick) begin
        pend_d = 1'b1;
      end
    end else begin
      if (sel_valid && slot_free) begin
        cap    = 1'b1;
        cap_ch = sel;
      end
    end

    // Out-of-range selects match no channel and therefore yield zero data.
    cap_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cap_ch == SEL_W'(k)) begin
        cap_word = data_in[k*WIDTH +: WIDTH];
      end
    end
    cap_err = (32'(cap_ch) >= CHANNELS);

    data_d  = data_q;
    ch_d    = ch_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (cap) begin
      data_d  = cap_word;
      ch_d    = cap_ch;
      err_d   = cap_err;
      valid_d = 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_DIRECT;
      presc_q <= '0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_ch    = ch_q;
  assign out_if.out_err   = err_q;
  assign out_if.out_valid = valid_q;

endmodule
